data_cache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's memory-stage port (ALUResultM, WriteDataM, MemWriteM, ReadDataM) and main memory.

- Read hits return data in the same cycle with no stall.
- Read misses stall the core while a full line is refilled by a request/grant + beat handshake.
- Every store is forwarded to memory. A store also updates the cache word only if it hits.

---
 rtl/data_cache.sv | 163 ++++++++++++++++
 tb/tb_data_cache.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// that sits between the core's memory stage and main memory.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   MemReadM          load access in the memory stage
//   MemWriteM         store access in the memory stage (wins over MemReadM)
//   ALUResultM        byte address; bits [1:0] are ignored (word accesses only)
//   WriteDataM        store data
//   ReadDataM         load data; valid when MemReadM=1 and StallM=0
//   StallM            core must hold the memory-stage access and stall
//   mem_req/mem_gnt   memory request, held until the grant cycle
//   mem_we            1 = single-word write, 0 = line read
//   mem_addr          write: word address; read: line-aligned address
//   mem_wdata         store data (0 when no request)
//   mem_rvalid/rdata  refill beats, ascending word order
//   dbgState          current FSM state (IDLE=0, REFILL_REQ=1, REFILL=2, WRITE=3)
//
// Handshake: a memory transaction is presented while mem_req=1 and is
// accepted in the cycle mem_gnt=1. Refill beats are accepted on every cycle
// mem_rvalid=1 while in REFILL; beats in any other state are dropped.
module data_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbgState
);

  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - OB - IB;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REFILL_REQ = 2'd1,
    REFILL     = 2'd2,
    WRITE      = 2'd3
  } state_t;

  state_t state;

  logic [29:0]   wordAddr;
  logic [OB-1:0] offset;
  logic [IB-1:0] index;
  logic [TW-1:0] addrTag;
  logic [1:0]    unusedByteBits;

  assign wordAddr       = ALUResultM[31:2];
  assign offset         = wordAddr[OB-1:0];
  assign index          = wordAddr[OB+IB-1:OB];
  assign addrTag        = wordAddr[29:OB+IB];
  assign unusedByteBits = ALUResultM[1:0];

  logic [31:0]      dataArr [LINES][WORDS];
  logic [TW-1:0]    tagArr  [LINES];
  logic [LINES-1:0] validArr;
  logic [OB-1:0]    beatCnt;

  logic hit;
  logic lastBeat;

  assign hit      = validArr[index] && (tagArr[index] == addrTag);
  assign lastBeat = (beatCnt == OB'(WORDS - 1));

  // Control state. The core holds its address stable while stalled, so the
  // index decoded from ALUResultM stays valid for the whole refill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      validArr <= '0;
      beatCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWriteM)
            state <= WRITE;
          else if (MemReadM && !hit)
            state <= REFILL_REQ;
        end
        REFILL_REQ: begin
          if (mem_gnt) begin
            beatCnt         <= '0;
            // The line is being overwritten; keep it invalid until complete.
            validArr[index] <= 1'b0;
            state           <= REFILL;
          end
        end
        REFILL: begin
          if (mem_rvalid) begin
            beatCnt <= beatCnt + OB'(1);
            if (lastBeat) begin
              validArr[index] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        WRITE: begin
          if (mem_gnt)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; writes are gated by the FSM state,
  // which is forced to IDLE while reset is low.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_rvalid) begin
      dataArr[index][beatCnt] <= mem_rdata;
      if (lastBeat)
        tagArr[index] <= addrTag;
    end
    if (state == WRITE && mem_gnt && hit)
      dataArr[index][offset] <= WriteDataM;
  end

  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:       StallM = MemWriteM || (MemReadM && !hit);
      REFILL_REQ: StallM = 1'b1;
      REFILL:     StallM = 1'b1;
      WRITE:      StallM = !mem_gnt;
      default:    StallM = 1'b1;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == REFILL_REQ) begin
      mem_req  = 1'b1;
      mem_addr = {wordAddr[29:OB], {OB{1'b0}}, 2'b00};
    end else if (state == WRITE) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = {wordAddr, 2'b00};
      mem_wdata = WriteDataM;
    end
  end

  assign ReadDataM = hit ? dataArr[index][offset] : 32'd0;
  assign dbgState  = state;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache (LINES=16, WORDS=4). Inputs change just after
// the falling edge; outputs are checked 1 time unit later, away from the
// rising edge where state updates.
module tb_data_cache;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  dbgState;

  int checks;
  int errors;

  data_cache #(.LINES(16), .WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dbgState   (dbgState)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives a full read miss on addr: detect, request, grant after gntDelay
  // extra cycles, four beats d0..d0+3, then the hit retry returning d0.
  task automatic do_refill(input logic [31:0] addr, input logic [31:0] d0, input int gntDelay);
    logic [31:0] lineAddr;
    lineAddr   = {addr[31:4], 4'h0};
    MemWriteM  = 1'b0;
    MemReadM   = 1'b1;
    ALUResultM = addr;
    #1 check("miss_detect_stall", 32'(StallM), 32'd1);
    tick();
    #1 check("req_valid", 32'(mem_req), 32'd1);
    check("req_we", 32'(mem_we), 32'd0);
    check("req_addr", mem_addr, lineAddr);
    check("req_stall", 32'(StallM), 32'd1);
    for (int i = 0; i < gntDelay; i++) begin
      tick();
      #1 check("req_held", 32'(mem_req), 32'd1);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + 32'(i);
      #1 check("beat_stall", 32'(StallM), 32'd1);
      check("beat_no_req", 32'(mem_req), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1 check("retry_stall", 32'(StallM), 32'd0);
    check("retry_data", ReadDataM, d0);
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    MemWriteM  = 1'b0;
    MemReadM   = 1'b1;
    ALUResultM = addr;
    #1 check("hit_stall", 32'(StallM), 32'd0);
    check("hit_data", ReadDataM, exp);
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = '0;
    WriteDataM = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset state with a pending load: IDLE, no request, stalled.
    tick();
    MemReadM   = 1'b1;
    ALUResultM = 32'h100;
    #1 check("rst_state", 32'(dbgState), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_stall", 32'(StallM), 32'd1);
    tick();
    reset = 1'b1;

    // First fill of 0x100 and hits in the same line.
    do_refill(32'h100, 32'hA0, 0);
    tick();
    read_hit(32'h10C, 32'hA3);
    read_hit(32'h108, 32'hA2);
    read_hit(32'h104, 32'hA1);

    // Conflict miss on index 0, then the evicted line misses again.
    do_refill(32'h500, 32'hB0, 1);
    tick();
    read_hit(32'h50C, 32'hB3);
    do_refill(32'h100, 32'hA0, 2);
    tick();

    // Store hit to 0x104 with the grant three stall cycles in.
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h104;
    WriteDataM = 32'hDEADBEEF;
    #1 check("st_idle_stall", 32'(StallM), 32'd1);
    tick();
    #1 check("st_state", 32'(dbgState), 32'd3);
    check("st_req", 32'(mem_req), 32'd1);
    check("st_we", 32'(mem_we), 32'd1);
    check("st_addr", mem_addr, 32'h104);
    check("st_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_stall_w1", 32'(StallM), 32'd1);
    tick();
    #1 check("st_stall_w2", 32'(StallM), 32'd1);
    tick();
    mem_gnt = 1'b1;
    #1 check("st_gnt_stall", 32'(StallM), 32'd0);
    tick();
    mem_gnt   = 1'b0;
    MemWriteM = 1'b0;
    #1 check("st_done_req", 32'(mem_req), 32'd0);
    read_hit(32'h104, 32'hDEADBEEF);
    read_hit(32'h108, 32'hA2);

    // Store miss to 0x900: memory write issued, index 0 line untouched.
    MemReadM   = 1'b0;
    MemWriteM  = 1'b1;
    ALUResultM = 32'h900;
    WriteDataM = 32'h12345678;
    tick();
    #1 check("stm_addr", mem_addr, 32'h900);
    check("stm_wdata", mem_wdata, 32'h12345678);
    mem_gnt = 1'b1;
    tick();
    mem_gnt   = 1'b0;
    MemWriteM = 1'b0;
    read_hit(32'h100, 32'hA0);
    read_hit(32'h104, 32'hDEADBEEF);
    MemReadM   = 1'b1;
    ALUResultM = 32'h900;
    #1 check("stm_no_alloc", 32'(StallM), 32'd1);
    MemReadM = 1'b0;
    tick();

    // Reset after two refill beats of 0x200.
    MemReadM   = 1'b1;
    ALUResultM = 32'h200;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hE0 + 32'(i);
      tick();
    end
    #1 check("pre_rst_state", 32'(dbgState), 32'd2);
    reset = 1'b0;
    #1 check("mid_rst_state", 32'(dbgState), 32'd0);
    check("mid_rst_req", 32'(mem_req), 32'd0);
    MemReadM = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hEE;
      tick();
      #1 check("ignored_beat_state", 32'(dbgState), 32'd0);
      check("ignored_beat_req", 32'(mem_req), 32'd0);
    end
    mem_rvalid = 1'b0;
    tick();
    do_refill(32'h200, 32'hC0, 0);
    tick();
    read_hit(32'h20C, 32'hC3);
    MemReadM   = 1'b1;
    ALUResultM = 32'h100;
    #1 check("post_rst_old_miss", 32'(StallM), 32'd1);
    MemReadM = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
